pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, max MEM_WAIT cycles without dmem_ack before error (range 1..255).
REQ-002 Parameter CNT_W, default 32, width of performance counters.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 id_branch  input  2  ID-stage branch type: 2'b00 none, 2'b01 conditional, 2'b1x jump.
REQ-006 ex_branch  input  2  EX-stage branch type, same encoding.
REQ-007 misprediction  input  1  EX-stage conditional branch resolved against prediction.
REQ-008 load_use  input  1  load-use hazard detected between ID and EX.
REQ-009 dmem_req  input  1  MEM stage holds a data-memory access.
REQ-010 dmem_ack  input  1  data memory completes access this cycle.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en  output  1 each  stage-register enables.
REQ-012 if_id_flush, id_ex_flush, mem_wb_bubble  output  1 each  bubble insertion into the named register.
REQ-013 mem_err  output  1  sticky memory-timeout error.
REQ-014 stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-015 States RUN, MEM_WAIT, ERROR; stage controls combinational from state and inputs, same-cycle effect.
REQ-016 Memory stall condition mstall = dmem_req && !dmem_ack, evaluated in RUN and MEM_WAIT.
REQ-017 When mstall: pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_bubble = 1; flushes = 0; other hazards ignored.
REQ-018 RUN->MEM_WAIT on mstall, wait counter loaded with 1.
REQ-019 MEM_WAIT: wait counter increments each mstall cycle; ->RUN on dmem_ack or on dmem_req deasserting; ->ERROR when counter equals MEM_TIMEOUT with mstall still true.
REQ-020 ERROR: all enables 0, all flush/bubble 0, mem_err = 1; exit only by reset.
REQ-021 Without mstall in RUN/MEM_WAIT, priority: misprediction > load_use > jump.
REQ-022 Misprediction (ex_branch == 2'b01 && misprediction): all enables 1, if_id_flush = 1, id_ex_flush = 1.
REQ-023 misprediction with ex_branch != 2'b01 is ignored.
REQ-024 load_use: pc_en = 0, if_id_en = 0, id_ex_flush = 1, id_ex_en/ex_mem_en = 1.
REQ-025 Jump (id_branch[1] == 1): all enables 1, if_id_flush = 1.
REQ-026 Simultaneous load_use and jump: load_use action only; jump reasserts next cycle since ID is held.
REQ-027 No event: all enables 1, all flush/bubble 0.
REQ-028 The cycle dmem_ack arrives in MEM_WAIT is a normal cycle evaluated per REQ-021..027.
REQ-029 stall_cnt increments each cycle pc_en == 0 while rst_n high, including ERROR; saturates at all-ones.
REQ-030 flush_cnt increments each cycle if_id_flush == 1; saturates at all-ones.

Reset
REQ-031 While rst_n low: state RUN, wait counter 0, mem_err 0, stall_cnt 0, flush_cnt 0, all enables 0, all flush/bubble 0.
REQ-032 Reset asserted mid-MEM_WAIT or in ERROR returns to RUN immediately, no partial counter retained.
REQ-033 First cycle after rst_n rises is evaluated as RUN.

Structure
REQ-034 Package pipeline_ctrl_pkg holds the state enum and branch encodings (BR_NONE 2'b00, BR_COND 2'b01, jump bit index 1).
REQ-035 One sub-module sat_counter (parameter width, inc input, async active-low reset) instantiated for stall_cnt and flush_cnt.

Verification
REQ-036 ex_branch=01, misprediction=1, load_use=1, id_branch=10 -> if_id_flush=1, id_ex_flush=1, pc_en=1; flush_cnt 0->1.
REQ-037 load_use=1 with id_branch=10 for 1 cycle then load_use=0 -> cycle1 pc_en=0, id_ex_flush=1, if_id_flush=0; cycle2 if_id_flush=1; stall_cnt=1, flush_cnt=1.
REQ-038 dmem_req=1, dmem_ack=0 for 3 cycles then ack=1 -> 3 cycles all en=0, mem_wb_bubble=1, state MEM_WAIT; ack cycle all en=1, next state RUN; stall_cnt=3.
REQ-039 MEM_TIMEOUT=4, dmem_req=1, dmem_ack never -> ERROR entered after 4th stall cycle, mem_err=1 stays; later dmem_ack=1 has no effect; rst_n pulse clears mem_err.
REQ-040 CNT_W=4, load_use held 20 cycles -> stall_cnt reaches 15 and holds.
REQ-041 rst_n low asynchronously mid-MEM_WAIT -> outputs reset immediately without clock edge; after release with no events all enables 1.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard/stall controller.
// Holds the controller state enum and the branch-type encodings.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam logic [1:0] BR_NONE     = 2'b00;
  localparam logic [1:0] BR_COND     = 2'b01;
  localparam int         BR_JUMP_BIT = 1;

  localparam int WAIT_W = 8;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Counts one per cycle while inc is high and holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: resolves memory stalls, mispredictions,
// load-use hazards and jumps into stage enables, and counts stall/flush cycles.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       id_branch,
  input  logic [1:0]       ex_branch,
  input  logic             misprediction,
  input  logic             load_use,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc;
  logic              mstall;
  logic              ex_mispredict;
  logic              id_is_jump;

  assign mstall        = dmem_req && !dmem_ack;
  assign wait_inc      = wait_q + 1'b1;
  assign ex_mispredict = (ex_branch == BR_COND) && misprediction;
  assign id_is_jump    = (id_branch != BR_NONE) && id_branch[BR_JUMP_BIT];

  // Outputs are forced low while rst_n is low so reset acts without a clock edge.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    mem_err       = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_ERROR: mem_err = 1'b1;
        default: begin
          if (mstall) begin
            mem_wb_bubble = 1'b1;
            if (state_q == ST_RUN) begin
              wait_d  = WAIT_W'(1);
              state_d = (TIMEOUT_V == WAIT_W'(1)) ? ST_ERROR : ST_MEM_WAIT;
            end else begin
              wait_d = wait_inc;
              if (wait_inc == TIMEOUT_V) state_d = ST_ERROR;
            end
          end else begin
            state_d   = ST_RUN;
            wait_d    = '0;
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            if (ex_mispredict) begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end else if (load_use) begin
              // Hold PC and IF/ID so a jump in ID re-presents next cycle.
              pc_en       = 1'b0;
              if_id_en    = 1'b0;
              id_ex_flush = 1'b1;
            end else if (id_is_jump) begin
              if_id_flush = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (if_id_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed checks of pipeline_ctrl against a cycle-level model,
// using a short-timeout/narrow-counter instance (a) and a default instance (b).
module tb_pipeline_ctrl;

  localparam int TO_A = 4;
  localparam int CW_A = 4;
  localparam int TO_B = 255;
  localparam int CW_B = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] id_branch = 2'b00;
  logic [1:0] ex_branch = 2'b00;
  logic misprediction = 1'b0;
  logic load_use = 1'b0;
  logic dmem_req = 1'b0;
  logic dmem_ack = 1'b0;

  logic pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, if_id_flush_a, id_ex_flush_a, mem_wb_bubble_a, mem_err_a;
  logic pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, if_id_flush_b, id_ex_flush_b, mem_wb_bubble_b, mem_err_b;
  logic [CW_A-1:0] stall_cnt_a, flush_cnt_a;
  logic [CW_B-1:0] stall_cnt_b, flush_cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: consecutive memory-stall cycles, sticky error, counters.
  int     run_a, run_b;
  bit     err_a, err_b;
  longint sc_a, fc_a, sc_b, fc_b;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(TO_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_branch(id_branch), .ex_branch(ex_branch),
    .misprediction(misprediction), .load_use(load_use), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_en(pc_en_a), .if_id_en(if_id_en_a), .id_ex_en(id_ex_en_a), .ex_mem_en(ex_mem_en_a),
    .if_id_flush(if_id_flush_a), .id_ex_flush(id_ex_flush_a), .mem_wb_bubble(mem_wb_bubble_a),
    .mem_err(mem_err_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipeline_ctrl #(.MEM_TIMEOUT(TO_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_branch(id_branch), .ex_branch(ex_branch),
    .misprediction(misprediction), .load_use(load_use), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_en(pc_en_b), .if_id_en(if_id_en_b), .id_ex_en(id_ex_en_b), .ex_mem_en(ex_mem_en_b),
    .if_id_flush(if_id_flush_b), .id_ex_flush(id_ex_flush_b), .mem_wb_bubble(mem_wb_bubble_b),
    .mem_err(mem_err_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {pc,if_id,id_ex,ex_mem enables, if_id_flush, id_ex_flush, bubble}.
  function automatic logic [6:0] model_ctl(input bit err);
    if (err) return 7'b0000_000;
    if (dmem_req && !dmem_ack) return 7'b0000_001;
    if (ex_branch == 2'b01 && misprediction) return 7'b1111_110;
    if (load_use) return 7'b0011_010;
    if (id_branch[1]) return 7'b1111_100;
    return 7'b1111_000;
  endfunction

  task automatic model_clear();
    run_a = 0; run_b = 0; err_a = 0; err_b = 0;
    sc_a = 0; fc_a = 0; sc_b = 0; fc_b = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ctl_a"}, {pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, if_id_flush_a, id_ex_flush_a, mem_wb_bubble_a, mem_err_a}, 0);
    check({tag, "_ctl_b"}, {pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, if_id_flush_b, id_ex_flush_b, mem_wb_bubble_b, mem_err_b}, 0);
    check({tag, "_cnt_a"}, {stall_cnt_a, flush_cnt_a}, 0);
    check({tag, "_cnt_b"}, {stall_cnt_b, flush_cnt_b}, 0);
  endtask

  task automatic set_idle();
    id_branch = 2'b00; ex_branch = 2'b00; misprediction = 1'b0;
    load_use = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  // Enter reset shortly after a rising edge, check outputs, release mid-cycle.
  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    set_idle();
    #1 check_zero_outputs("rst");
    model_clear();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic [6:0] ea, eb;
    bit ms;
    @(negedge clk);
    ea = model_ctl(err_a);
    eb = model_ctl(err_b);
    ms = dmem_req && !dmem_ack;
    check("ctl_a", {pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, if_id_flush_a, id_ex_flush_a, mem_wb_bubble_a}, ea);
    check("ctl_b", {pc_en_b, if_id_en_b, id_ex_en_b, ex_mem_en_b, if_id_flush_b, id_ex_flush_b, mem_wb_bubble_b}, eb);
    check("err_a", mem_err_a, err_a);
    check("err_b", mem_err_b, err_b);
    check("cnt_a", {stall_cnt_a, flush_cnt_a}, {4'(sc_a), 4'(fc_a)});
    check("cnt_b", {stall_cnt_b, flush_cnt_b}, {32'(sc_b), 32'(fc_b)});
    @(posedge clk);
    if (!ea[6] && sc_a < 15) sc_a++;
    if (ea[2] && fc_a < 15) fc_a++;
    if (!eb[6] && sc_b < 64'hFFFF_FFFF) sc_b++;
    if (eb[2] && fc_b < 64'hFFFF_FFFF) fc_b++;
    if (!err_a) begin
      run_a = ms ? run_a + 1 : 0;
      if (run_a >= TO_A) err_a = 1;
    end
    if (!err_b) begin
      run_b = ms ? run_b + 1 : 0;
      if (run_b >= TO_B) err_b = 1;
    end
    #1;
  endtask

  initial begin
    model_clear();
    #2 check_zero_outputs("init");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Misprediction beats load_use and jump.
    do_reset();
    ex_branch = 2'b01; misprediction = 1; load_use = 1; id_branch = 2'b10;
    cycle();
    check("mispred_fcnt", flush_cnt_b, 1);
    $display("directed: mispredict over load_use/jump done");

    // load_use with a pending jump, then the jump goes through.
    do_reset();
    load_use = 1; id_branch = 2'b10;
    cycle();
    load_use = 0;
    cycle();
    check("lu_jump_cnts", {stall_cnt_b, flush_cnt_b}, {32'd1, 32'd1});
    $display("directed: load_use then jump done");

    // Three memory-stall cycles then acknowledge.
    do_reset();
    set_idle(); dmem_req = 1;
    repeat (3) cycle();
    dmem_ack = 1;
    cycle();
    set_idle();
    cycle();
    check("memwait_scnt", stall_cnt_b, 3);
    $display("directed: three-cycle memory wait done");

    // Timeout on instance a; late ack ignored; reset clears the error.
    do_reset();
    dmem_req = 1;
    repeat (TO_A) cycle();
    check("timeout_err_a", mem_err_a, 1);
    check("timeout_err_b", mem_err_b, 0);
    dmem_ack = 1;
    repeat (3) cycle();
    check("late_ack_err_a", mem_err_a, 1);
    do_reset();
    check("rst_clears_err", mem_err_a, 0);
    $display("directed: memory timeout and error recovery done");

    // Stall counter saturation on the narrow instance.
    do_reset();
    load_use = 1;
    repeat (20) cycle();
    check("sat_scnt_a", stall_cnt_a, 15);
    check("sat_scnt_b", stall_cnt_b, 20);
    $display("directed: stall counter saturation done");

    // Asynchronous reset in the middle of a memory wait.
    do_reset();
    set_idle(); dmem_req = 1;
    repeat (2) cycle();
    #1 rst_n = 1'b0;
    #1 check_zero_outputs("async_rst");
    model_clear();
    set_idle();
    @(posedge clk);
    #2 rst_n = 1'b1;
    cycle();
    check("post_rst_en", {pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a}, 4'b1111);
    $display("directed: async reset mid memory wait done");

    // Randomized blocks with varying memory behaviour.
    for (int blk = 0; blk < 12; blk++) begin
      int ack_pct;
      int req_pct;
      ack_pct = (blk % 3 == 0) ? 5 : $urandom_range(20, 80);
      req_pct = $urandom_range(10, 60);
      do_reset();
      for (int c = 0; c < 80; c++) begin
        id_branch     = 2'($urandom_range(0, 3));
        ex_branch     = 2'($urandom_range(0, 3));
        misprediction = ($urandom_range(0, 99) < 30);
        load_use      = ($urandom_range(0, 99) < 30);
        if (!dmem_req || dmem_ack || $urandom_range(0, 99) < 10) begin
          dmem_req = ($urandom_range(0, 99) < req_pct);
        end
        dmem_ack = dmem_req && ($urandom_range(0, 99) < ack_pct);
        cycle();
      end
      $display("random block %0d: ack_pct=%0d req_pct=%0d stall_b=%0d flush_b=%0d", blk, ack_pct, req_pct, stall_cnt_b, flush_cnt_b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
